mem_stage_ctrl: RTL and testbench

//   MEM-stage access controller between the EX/MEM register and memory_register (MEM/WB).

---
 rtl/mem_stage_ctrl.sv | 163 ++++++++++++++++
 tb/tb_mem_stage_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_ctrl.sv
// MEM-stage access controller: D-cache req/ready handshake, pipeline freeze, load alignment.
// Optional stall-cycle counter enabled by defining MEM_STALL_CNT_EN.
module mem_stage_ctrl #(
    parameter int XLEN        = 32,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ex_valid,
    input  logic                   ex_is_load,
    input  logic                   ex_is_store,
    input  logic                   ex_is_byte,
    input  logic [XLEN-1:0]        ex_alu_result,
    input  logic [XLEN-1:0]        ex_store_data,
    input  logic [4:0]             ex_rd,
    input  logic                   ex_is_write,
    output logic                   dc_req,
    output logic                   dc_we,
    output logic [XLEN-1:0]        dc_addr,
    output logic [XLEN-1:0]        dc_wdata,
    output logic [3:0]             dc_be,
    input  logic                   dc_ready,
    input  logic [XLEN-1:0]        dc_rdata,
    output logic                   stall_out,
    output logic                   exc_misaligned,
    output logic [XLEN-1:0]        wb_data_out,
    output logic [4:0]             rd_out,
    output logic                   is_write_out,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t state_q, state_d;

    logic            cap_we;
    logic [XLEN-1:0] cap_addr;
    logic [XLEN-1:0] cap_wdata;
    logic [3:0]      cap_be;
    logic            cap_byte;
    logic [4:0]      cap_rd;
    logic            cap_is_write;

    logic            is_mem;
    logic            misaligned;
    logic            mem_op;
    logic            capture;
    logic [3:0]      ex_be;
    logic [XLEN-1:0] ex_wdata;

    logic            cur_we;
    logic [XLEN-1:0] cur_addr;
    logic [XLEN-1:0] cur_wdata;
    logic [3:0]      cur_be;
    logic            cur_byte;
    logic [7:0]      lane;
    logic [XLEN-1:0] load_data;

    assign is_mem     = ex_is_load | ex_is_store;
    assign misaligned = ex_valid & is_mem & ~ex_is_byte
                      & (ex_alu_result[1:0] != 2'b00);
    assign mem_op     = ex_valid & is_mem & ~misaligned;

    assign ex_be    = ex_is_byte ? (4'b0001 << ex_alu_result[1:0]) : 4'b1111;
    assign ex_wdata = ex_is_byte ? {(XLEN/8){ex_store_data[7:0]}}
                                 : ex_store_data;

    // WAIT replays the captured request so the cache sees stable fields.
    assign cur_we    = (state_q == WAIT) ? cap_we    : ex_is_store;
    assign cur_addr  = (state_q == WAIT) ? cap_addr  : ex_alu_result;
    assign cur_wdata = (state_q == WAIT) ? cap_wdata : ex_wdata;
    assign cur_be    = (state_q == WAIT) ? cap_be    : ex_be;
    assign cur_byte  = (state_q == WAIT) ? cap_byte  : ex_is_byte;

    assign lane      = dc_rdata[{cur_addr[1:0], 3'b000} +: 8];
    assign load_data = cur_byte ? {{(XLEN-8){lane[7]}}, lane} : dc_rdata;

    always_comb begin
        state_d        = state_q;
        capture        = 1'b0;
        dc_req         = 1'b0;
        dc_we          = cur_we;
        dc_addr        = {cur_addr[XLEN-1:2], 2'b00};
        dc_wdata       = cur_wdata;
        dc_be          = cur_be;
        exc_misaligned = 1'b0;
        wb_data_out    = ex_alu_result;
        rd_out         = ex_rd;
        is_write_out   = 1'b0;
        if (reset) begin
            wb_data_out = '0;
            rd_out      = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (misaligned) begin
                        exc_misaligned = 1'b1;
                    end else if (mem_op) begin
                        dc_req = 1'b1;
                        if (dc_ready) begin
                            wb_data_out  = load_data;
                            is_write_out = ~ex_is_store & ex_is_write;
                        end else begin
                            capture = 1'b1;
                            state_d = WAIT;
                        end
                    end else if (ex_valid) begin
                        is_write_out = ex_is_write;
                    end
                end
                WAIT: begin
                    dc_req      = 1'b1;
                    rd_out      = cap_rd;
                    wb_data_out = load_data;
                    if (dc_ready) begin
                        is_write_out = ~cap_we & cap_is_write;
                        state_d      = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign stall_out = dc_req & ~dc_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cap_we       <= 1'b0;
            cap_addr     <= '0;
            cap_wdata    <= '0;
            cap_be       <= '0;
            cap_byte     <= 1'b0;
            cap_rd       <= '0;
            cap_is_write <= 1'b0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cap_we       <= ex_is_store;
                cap_addr     <= ex_alu_result;
                cap_wdata    <= ex_wdata;
                cap_be       <= ex_be;
                cap_byte     <= ex_is_byte;
                cap_rd       <= ex_rd;
                cap_is_write <= ex_is_write;
            end
        end
    end

`ifdef MEM_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_out) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: directed loads/stores, misaligned, reset-in-WAIT.
// Stall counter checks active when MEM_STALL_CNT_EN is defined.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_is_load, ex_is_store, ex_is_byte;
    logic [31:0] ex_alu_result, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_is_write;
    logic        dc_req, dc_we;
    logic [31:0] dc_addr, dc_wdata;
    logic [3:0]  dc_be;
    logic        dc_ready;
    logic [31:0] dc_rdata;
    logic        stall_out, exc_misaligned;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        is_write_out;
    logic [31:0] stall_cnt;

    mem_stage_ctrl #(.XLEN(32), .STALL_CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_is_load(ex_is_load),
        .ex_is_store(ex_is_store), .ex_is_byte(ex_is_byte),
        .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_is_write(ex_is_write),
        .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
        .dc_wdata(dc_wdata), .dc_be(dc_be),
        .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .stall_out(stall_out), .exc_misaligned(exc_misaligned),
        .wb_data_out(wb_data_out), .rd_out(rd_out),
        .is_write_out(is_write_out), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // kind: 0 = ALU passthrough, 1 = memory access, 2 = misaligned
    typedef struct {
        int          kind;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] wb;
        logic [4:0]  rd;
        logic        isw;
        int          stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   stall_run = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_run = 0;
        end else begin
            if (stall_out) begin
                stall_run++;
                if (exp_q.size() > 0) begin
                    chk("stall_addr", dc_addr, exp_q[0].addr);
                    chk("stall_be", {28'd0, dc_be}, {28'd0, exp_q[0].be});
                    chk("stall_isw", {31'd0, is_write_out}, 32'd0);
                end
            end
            if (exc_misaligned || (dc_req && dc_ready) ||
                (ex_valid && !ex_is_load && !ex_is_store)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("exc", {31'd0, exc_misaligned}, (e.kind == 2) ? 32'd1 : 32'd0);
                    chk("isw", {31'd0, is_write_out}, {31'd0, e.isw});
                    if (e.kind != 1) begin
                        chk("req_off", {31'd0, dc_req}, 32'd0);
                        chk("stall_off", {31'd0, stall_out}, 32'd0);
                    end else begin
                        chk("we", {31'd0, dc_we}, {31'd0, e.we});
                        chk("addr", dc_addr, e.addr);
                        chk("be", {28'd0, dc_be}, {28'd0, e.be});
                        if (e.we) chk("wdata", dc_wdata, e.wdata);
                        chk("stalls", stall_run, e.stalls);
                    end
                    if (e.isw) begin
                        chk("wb_data", wb_data_out, e.wb);
                        chk("rd", {27'd0, rd_out}, {27'd0, e.rd});
                    end
                end
                stall_run = 0;
            end
        end
    end

    task automatic idle_inputs();
        ex_valid = 0; ex_is_load = 0; ex_is_store = 0; ex_is_byte = 0;
        ex_alu_result = 0; ex_store_data = 0; ex_rd = 0; ex_is_write = 0;
        dc_ready = 0; dc_rdata = 0;
    endtask

    // Presents one instruction; cache answers after dly cycles.
    task automatic issue(input logic ld, st, byt, input logic [31:0] a, sd,
                         input logic [4:0] rd, input logic w,
                         input int dly, input logic [31:0] rdata);
        ex_valid = 1; ex_is_load = ld; ex_is_store = st; ex_is_byte = byt;
        ex_alu_result = a; ex_store_data = sd; ex_rd = rd; ex_is_write = w;
        dc_rdata = rdata;
        dc_ready = (dly == 0);
        for (int i = 0; i < dly; i++) begin
            @(posedge clk); #1;
            if (i == dly - 1) dc_ready = 1;
        end
        @(posedge clk); #1;
        idle_inputs();
    endtask

    task automatic do_reset();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        ex_valid = 1; ex_alu_result = 32'h55; ex_rd = 5'd3; ex_is_write = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_isw", {31'd0, is_write_out}, 32'd0);
        chk("rst_wb", wb_data_out, 32'd0);
        chk("rst_rd", {27'd0, rd_out}, 32'd0);
        chk("rst_req", {31'd0, dc_req}, 32'd0);
        chk("rst_stall", {31'd0, stall_out}, 32'd0);
        chk("rst_exc", {31'd0, exc_misaligned}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        idle_inputs();
        @(negedge clk);
        chk("novalid_isw", {31'd0, is_write_out}, 32'd0);
        chk("novalid_req", {31'd0, dc_req}, 32'd0);
        @(posedge clk); #1;

        exp_q.push_back('{1, 0, 32'h100, 32'h0, 4'hF, 32'hDEADBEEF, 5'd5, 1, 0});
        issue(1, 0, 0, 32'h100, 32'h0, 5'd5, 1, 0, 32'hDEADBEEF);

        exp_q.push_back('{1, 0, 32'h100, 32'h0, 4'b1000, 32'hFFFFFF80, 5'd6, 1, 3});
        issue(1, 0, 1, 32'h103, 32'h0, 5'd6, 1, 3, 32'h80112233);

        exp_q.push_back('{1, 1, 32'h200, 32'hA5A5A5A5, 4'b0100, 32'h0, 5'd0, 0, 1});
        issue(0, 1, 1, 32'h202, 32'h123456A5, 5'd0, 0, 1, 32'h0);

        exp_q.push_back('{1, 1, 32'h300, 32'h11223344, 4'hF, 32'h0, 5'd0, 0, 0});
        issue(0, 1, 0, 32'h300, 32'h11223344, 5'd0, 0, 0, 32'h0);

        exp_q.push_back('{2, 0, 32'h0, 32'h0, 4'h0, 32'h0, 5'd0, 0, 0});
        issue(1, 0, 0, 32'h101, 32'h0, 5'd8, 1, 0, 32'h0);

        exp_q.push_back('{1, 0, 32'h100, 32'h0, 4'b0010, 32'h0000007F, 5'd9, 1, 2});
        issue(1, 0, 1, 32'h101, 32'h0, 5'd9, 1, 2, 32'h00007F00);

        exp_q.push_back('{1, 0, 32'h104, 32'h0, 4'b0001, 32'hFFFFFFC3, 5'd10, 1, 0});
        issue(1, 0, 1, 32'h104, 32'h0, 5'd10, 1, 0, 32'h000000C3);

        exp_q.push_back('{1, 1, 32'h204, 32'hCAFEF00D, 4'hF, 32'h0, 5'd0, 0, 0});
        issue(1, 1, 0, 32'h204, 32'hCAFEF00D, 5'd11, 1, 0, 32'h0);

        exp_q.push_back('{0, 0, 32'h0, 32'h0, 4'h0, 32'h12345678, 5'd7, 1, 0});
        issue(0, 0, 0, 32'h12345678, 32'h0, 5'd7, 1, 0, 32'h0);

        // reset while a miss is outstanding
        ex_valid = 1; ex_is_load = 1; ex_alu_result = 32'h400;
        ex_rd = 5'd12; ex_is_write = 1; dc_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        idle_inputs();
        @(negedge clk);
        chk("rstwait_req", {31'd0, dc_req}, 32'd0);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("postrst_req", {31'd0, dc_req}, 32'd0);
        chk("postrst_stall", {31'd0, stall_out}, 32'd0);
        @(posedge clk); #1;
        exp_q.push_back('{1, 0, 32'h500, 32'h0, 4'hF, 32'h01020304, 5'd13, 1, 1});
        issue(1, 0, 0, 32'h500, 32'h0, 5'd13, 1, 1, 32'h01020304);

`ifdef MEM_STALL_CNT_EN
        do_reset();
        exp_q.push_back('{1, 0, 32'h600, 32'h0, 4'hF, 32'hAAAA5555, 5'd14, 1, 4});
        issue(1, 0, 0, 32'h600, 32'h0, 5'd14, 1, 4, 32'hAAAA5555);
        exp_q.push_back('{1, 0, 32'h604, 32'h0, 4'hF, 32'h5555AAAA, 5'd15, 1, 2});
        issue(1, 0, 0, 32'h604, 32'h0, 5'd15, 1, 2, 32'h5555AAAA);
        @(negedge clk);
        chk("stall_cnt", stall_cnt, 32'd6);
`else
        @(negedge clk);
        chk("stall_cnt_tied", stall_cnt, 32'd0);
`endif

        for (int i = 0; i < 50 && exp_q.size() > 0; i++) @(posedge clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
